// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared types and constants for the memory access stage
`timescale 1ns/1ps
package mem_access_stage_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_AW = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } mem_state_e;

  // A bubble only kills valid and regWe; data fields keep their old contents.
  localparam logic BUBBLE_VALID = 1'b0;
  localparam logic BUBBLE_REGWE = 1'b0;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - access wait counter with clear/enable/expire
`timescale 1ns/1ps
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Expires during the MAX_WAIT-th enabled cycle, so the caller can still honour an ack in it.
  assign expire_o = en_i && (cnt_q == CNT_W'(MAX_WAIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage with req/ack data-memory handshake and MEM/WB register
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
`timescale 1ns/1ps
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
`ifdef MEM_TIMEOUT_EN
  , parameter int MAX_WAIT = 15
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_memRe,
  input  logic              ex_memWe,
  input  logic [DATA_W-1:0] ex_aluResult,
  input  logic [DATA_W-1:0] ex_wrtData,
  input  logic [DATA_W-1:0] ex_pcNext,
  input  logic [REG_AW-1:0] ex_regAddr,
  input  logic              ex_regWe,
  input  logic              ex_jal,
  input  logic              ex_memToReg,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              mem_err,
  output logic              valid_MEM_WB,
  output logic              regWe_MEM_WB,
  output logic              jal_MEM_WB,
  output logic              memToReg_MEM_WB,
  output logic [REG_AW-1:0] regAddr_MEM_WB,
  output logic [DATA_W-1:0] aluResult_MEM_WB,
  output logic [DATA_W-1:0] pcNext_MEM_WB,
  output logic [DATA_W-1:0] memData_MEM_WB
);

  mem_state_e state_q, state_d;

  logic              mem_start;
  logic              timeout;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rd_hold_q, rd_hold_d;
  logic              mem_err_q, mem_err_d;

  logic              wb_valid_q, wb_valid_d;
  logic              wb_regwe_q, wb_regwe_d;
  logic              wb_jal_q, wb_jal_d;
  logic              wb_m2r_q, wb_m2r_d;
  logic [REG_AW-1:0] wb_ra_q, wb_ra_d;
  logic [DATA_W-1:0] wb_alu_q, wb_alu_d;
  logic [DATA_W-1:0] wb_pc_q, wb_pc_d;
  logic [DATA_W-1:0] wb_md_q, wb_md_d;

  assign mem_start = ex_valid && (ex_memRe || ex_memWe);

`ifdef MEM_TIMEOUT_EN
  logic wait_expire;

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q != ACCESS),
    .en_i     (state_q == ACCESS),
    .expire_o (wait_expire)
  );

  // An ack arriving on the expiry cycle completes normally.
  assign timeout = wait_expire && !mem_ack;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (mem_start) state_d = ACCESS;
      ACCESS:   if (mem_ack || timeout) state_d = COMPLETE;
      COMPLETE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    case (state_q)
      IDLE:    stall = mem_start;
      ACCESS:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_hold_d   = rd_hold_q;
    mem_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_start) begin
          mem_req_d   = 1'b1;
          mem_we_d    = ex_memWe;
          mem_addr_d  = ex_aluResult;
          mem_wdata_d = ex_wrtData;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) rd_hold_d = mem_rdata;
        end else if (timeout) begin
          mem_req_d = 1'b0;
          mem_err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_regwe_d = wb_regwe_q;
    wb_jal_d   = wb_jal_q;
    wb_m2r_d   = wb_m2r_q;
    wb_ra_d    = wb_ra_q;
    wb_alu_d   = wb_alu_q;
    wb_pc_d    = wb_pc_q;
    wb_md_d    = wb_md_q;
    case (state_q)
      IDLE: begin
        // Entering an access bubbles MEM/WB so the older instruction writes back once.
        if (mem_start || !ex_valid) begin
          wb_valid_d = BUBBLE_VALID;
          wb_regwe_d = BUBBLE_REGWE;
        end else begin
          wb_valid_d = 1'b1;
          wb_regwe_d = ex_regWe;
          wb_jal_d   = ex_jal;
          wb_m2r_d   = ex_memToReg;
          wb_ra_d    = ex_regAddr;
          wb_alu_d   = ex_aluResult;
          wb_pc_d    = ex_pcNext;
        end
      end
      COMPLETE: begin
        wb_valid_d = ex_valid;
        wb_regwe_d = ex_regWe && !mem_err_q;
        wb_jal_d   = ex_jal;
        wb_m2r_d   = ex_memToReg;
        wb_ra_d    = ex_regAddr;
        wb_alu_d   = ex_aluResult;
        wb_pc_d    = ex_pcNext;
        wb_md_d    = (mem_we_q || mem_err_q) ? '0 : rd_hold_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_hold_q   <= '0;
      mem_err_q   <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_regwe_q  <= 1'b0;
      wb_jal_q    <= 1'b0;
      wb_m2r_q    <= 1'b0;
      wb_ra_q     <= '0;
      wb_alu_q    <= '0;
      wb_pc_q     <= '0;
      wb_md_q     <= '0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_hold_q   <= rd_hold_d;
      mem_err_q   <= mem_err_d;
      wb_valid_q  <= wb_valid_d;
      wb_regwe_q  <= wb_regwe_d;
      wb_jal_q    <= wb_jal_d;
      wb_m2r_q    <= wb_m2r_d;
      wb_ra_q     <= wb_ra_d;
      wb_alu_q    <= wb_alu_d;
      wb_pc_q     <= wb_pc_d;
      wb_md_q     <= wb_md_d;
    end
  end

  assign mem_req          = mem_req_q;
  assign mem_we           = mem_we_q;
  assign mem_addr         = mem_addr_q;
  assign mem_wdata        = mem_wdata_q;
  assign mem_err          = mem_err_q;
  assign valid_MEM_WB     = wb_valid_q;
  assign regWe_MEM_WB     = wb_regwe_q;
  assign jal_MEM_WB       = wb_jal_q;
  assign memToReg_MEM_WB  = wb_m2r_q;
  assign regAddr_MEM_WB   = wb_ra_q;
  assign aluResult_MEM_WB = wb_alu_q;
  assign pcNext_MEM_WB    = wb_pc_q;
  assign memData_MEM_WB   = wb_md_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
`timescale 1ns/1ps
module tb_mem_access_stage;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          ex_valid, ex_memRe, ex_memWe;
  logic [DW-1:0] ex_aluResult, ex_wrtData, ex_pcNext;
  logic [AW-1:0] ex_regAddr;
  logic          ex_regWe, ex_jal, ex_memToReg;
  logic          mem_req, mem_we;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          stall, mem_err;
  logic          valid_MEM_WB, regWe_MEM_WB, jal_MEM_WB, memToReg_MEM_WB;
  logic [AW-1:0] regAddr_MEM_WB;
  logic [DW-1:0] aluResult_MEM_WB, pcNext_MEM_WB, memData_MEM_WB;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] ra;
    logic          we;
    logic          jal;
    logic          m2r;
    logic [DW-1:0] alu;
    logic [DW-1:0] pc;
    logic [DW-1:0] md;
    bit            chk_md;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  mem_access_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_valid         (ex_valid),
    .ex_memRe         (ex_memRe),
    .ex_memWe         (ex_memWe),
    .ex_aluResult     (ex_aluResult),
    .ex_wrtData       (ex_wrtData),
    .ex_pcNext        (ex_pcNext),
    .ex_regAddr       (ex_regAddr),
    .ex_regWe         (ex_regWe),
    .ex_jal           (ex_jal),
    .ex_memToReg      (ex_memToReg),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_ack          (mem_ack),
    .mem_rdata        (mem_rdata),
    .stall            (stall),
    .mem_err          (mem_err),
    .valid_MEM_WB     (valid_MEM_WB),
    .regWe_MEM_WB     (regWe_MEM_WB),
    .jal_MEM_WB       (jal_MEM_WB),
    .memToReg_MEM_WB  (memToReg_MEM_WB),
    .regAddr_MEM_WB   (regAddr_MEM_WB),
    .aluResult_MEM_WB (aluResult_MEM_WB),
    .pcNext_MEM_WB    (pcNext_MEM_WB),
    .memData_MEM_WB   (memData_MEM_WB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 200000", $time);
    $fatal(1);
  end

  // Every valid MEM/WB entry must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid_MEM_WB === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got valid MEM/WB ra=%0d alu=%h, required no entry", regAddr_MEM_WB, aluResult_MEM_WB);
      end else begin
        mon_e = sb.pop_front();
        if (regAddr_MEM_WB !== mon_e.ra || regWe_MEM_WB !== mon_e.we || jal_MEM_WB !== mon_e.jal ||
            memToReg_MEM_WB !== mon_e.m2r || aluResult_MEM_WB !== mon_e.alu || pcNext_MEM_WB !== mon_e.pc ||
            (mon_e.chk_md && memData_MEM_WB !== mon_e.md)) begin
          errors++;
          $display("FAIL sb_mem_wb: got ra=%0d we=%b jal=%b m2r=%b alu=%h pc=%h md=%h, required ra=%0d we=%b jal=%b m2r=%b alu=%h pc=%h md=%h",
                   regAddr_MEM_WB, regWe_MEM_WB, jal_MEM_WB, memToReg_MEM_WB, aluResult_MEM_WB, pcNext_MEM_WB, memData_MEM_WB,
                   mon_e.ra, mon_e.we, mon_e.jal, mon_e.m2r, mon_e.alu, mon_e.pc, mon_e.md);
        end
      end
    end
  end

  task automatic set_idle();
    ex_valid = 0; ex_memRe = 0; ex_memWe = 0; ex_aluResult = '0; ex_wrtData = '0;
    ex_pcNext = '0; ex_regAddr = '0; ex_regWe = 0; ex_jal = 0; ex_memToReg = 0;
  endtask

  task automatic push_exp(input logic [AW-1:0] ra, input logic we, input logic jal, input logic m2r,
                          input logic [DW-1:0] alu, input logic [DW-1:0] pc, input logic [DW-1:0] md, input bit chk);
    exp_t e;
    e.ra = ra; e.we = we; e.jal = jal; e.m2r = m2r; e.alu = alu; e.pc = pc; e.md = md; e.chk_md = chk;
    sb.push_back(e);
  endtask

  task automatic drive_alu(input logic [AW-1:0] ra, input logic [DW-1:0] res, input logic jal, input logic [DW-1:0] pc);
    ex_valid = 1; ex_memRe = 0; ex_memWe = 0; ex_aluResult = res; ex_wrtData = 16'h0F0F;
    ex_pcNext = pc; ex_regAddr = ra; ex_regWe = 1; ex_jal = jal; ex_memToReg = 0;
    push_exp(ra, 1'b1, jal, 1'b0, res, pc, '0, 1'b0);
  endtask

  // Memory responder: ack in the ack_at-th cycle mem_req is high (0 = never); records observations only.
  task automatic do_access(input logic [DW-1:0] addr, input logic [DW-1:0] wdata, input logic re, input logic we,
                           input logic [AW-1:0] ra, input logic rwe, input int ack_at, input logic [DW-1:0] rdata,
                           output int stalls, output int reqs, output int errs, output int bad, output bit hung);
    stalls = 0; reqs = 0; errs = 0; bad = 0; hung = 1;
    ex_valid = 1; ex_memRe = re; ex_memWe = we; ex_aluResult = addr; ex_wrtData = wdata;
    ex_pcNext = addr + 16'd2; ex_regAddr = ra; ex_regWe = rwe; ex_jal = 0; ex_memToReg = re & ~we;
    for (int c = 0; c < 100; c++) begin
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
        reqs++;
        if (mem_we !== we || mem_addr !== addr || mem_wdata !== wdata) bad++;
        if (reqs == ack_at) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
        end
      end
      #1;
      if (mem_err === 1'b1) errs++;
      if (stall !== 1'b1) begin
        hung = 0;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_err, stall} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got req/we/err/stall=%b%b%b%b, required 0000", mem_req, mem_we, mem_err, stall);
    end
    checks++;
    if ({valid_MEM_WB, regWe_MEM_WB, jal_MEM_WB, memToReg_MEM_WB} !== 4'b0000 || regAddr_MEM_WB !== '0) begin
      errors++; $display("FAIL reset_wb_ctrl: got v/we/jal/m2r=%b%b%b%b ra=%0d, required all 0",
                         valid_MEM_WB, regWe_MEM_WB, jal_MEM_WB, memToReg_MEM_WB, regAddr_MEM_WB);
    end
    checks++;
    if ({aluResult_MEM_WB, pcNext_MEM_WB, memData_MEM_WB, mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_data: got alu=%h pc=%h md=%h addr=%h wdata=%h, required all 0",
                         aluResult_MEM_WB, pcNext_MEM_WB, memData_MEM_WB, mem_addr, mem_wdata);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    mem_ack = 1'b1;
    mem_rdata = 16'hDEAD;
    drive_alu(4'd5, 16'h1234, 1'b0, 16'h0100);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall_1: got stall=%b, required 0", stall); end
    @(negedge clk);
    checks++;
    if (regAddr_MEM_WB !== 4'd5 || aluResult_MEM_WB !== 16'h1234 || mem_req !== 1'b0) begin
      errors++; $display("FAIL b2b_wb_1: got ra=%0d alu=%h req=%b, required ra=5 alu=1234 req=0", regAddr_MEM_WB, aluResult_MEM_WB, mem_req);
    end
    drive_alu(4'd6, 16'h5678, 1'b1, 16'h0102);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall_2: got stall=%b, required 0", stall); end
    @(negedge clk);
    checks++;
    if (regAddr_MEM_WB !== 4'd6 || aluResult_MEM_WB !== 16'h5678 || jal_MEM_WB !== 1'b1) begin
      errors++; $display("FAIL b2b_wb_2: got ra=%0d alu=%h jal=%b, required ra=6 alu=5678 jal=1", regAddr_MEM_WB, aluResult_MEM_WB, jal_MEM_WB);
    end
    set_idle();
    mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_MEM_WB !== 1'b0 || regWe_MEM_WB !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL b2b_idle_bubble: got valid=%b regWe=%b req=%b, required 0 0 0", valid_MEM_WB, regWe_MEM_WB, mem_req);
    end
  endtask

  task automatic test_load();
    int st, rq, er, bad;
    bit hung;
    push_exp(4'd3, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0042, 16'hBEEF, 1'b1);
    do_access(16'h0040, 16'h0000, 1'b1, 1'b0, 4'd3, 1'b1, 3, 16'hBEEF, st, rq, er, bad, hung);
    checks++;
    if (hung || st != 4) begin errors++; $display("FAIL load_stall_cycles: got %0d (hung=%0d), required 4", st, hung); end
    checks++;
    if (rq != 3 || bad != 0 || er != 0) begin
      errors++; $display("FAIL load_handshake: got req_cycles=%0d unstable=%0d err=%0d, required 3 0 0", rq, bad, er);
    end
    checks++;
    if (memData_MEM_WB !== 16'hBEEF || regAddr_MEM_WB !== 4'd3 || regWe_MEM_WB !== 1'b1 ||
        memToReg_MEM_WB !== 1'b1 || valid_MEM_WB !== 1'b1) begin
      errors++; $display("FAIL load_wb: got md=%h ra=%0d we=%b m2r=%b v=%b, required BEEF 3 1 1 1",
                         memData_MEM_WB, regAddr_MEM_WB, regWe_MEM_WB, memToReg_MEM_WB, valid_MEM_WB);
    end
  endtask

  task automatic test_store();
    int st, rq, er, bad;
    bit hung;
    push_exp(4'd2, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0012, '0, 1'b0);
    do_access(16'h0010, 16'hA5A5, 1'b0, 1'b1, 4'd2, 1'b0, 1, 16'hFFFF, st, rq, er, bad, hung);
    checks++;
    if (hung || st != 2) begin errors++; $display("FAIL store_stall_cycles: got %0d (hung=%0d), required 2", st, hung); end
    checks++;
    if (rq != 1 || bad != 0) begin
      errors++; $display("FAIL store_req_stable: got req_cycles=%0d unstable=%0d, required 1 0", rq, bad);
    end
    checks++;
    if (regWe_MEM_WB !== 1'b0 || valid_MEM_WB !== 1'b1 || aluResult_MEM_WB !== 16'h0010) begin
      errors++; $display("FAIL store_wb: got we=%b v=%b alu=%h, required 0 1 0010", regWe_MEM_WB, valid_MEM_WB, aluResult_MEM_WB);
    end
  endtask

  task automatic test_store_priority();
    int st, rq, er, bad;
    bit hung;
    push_exp(4'd4, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0022, 16'h0000, 1'b1);
    do_access(16'h0020, 16'h3C3C, 1'b1, 1'b1, 4'd4, 1'b0, 2, 16'h1111, st, rq, er, bad, hung);
    checks++;
    if (hung || st != 3 || rq != 2 || bad != 0) begin
      errors++; $display("FAIL prio_access: got stalls=%0d req_cycles=%0d unstable=%0d, required 3 2 0", st, rq, bad);
    end
    checks++;
    if (memData_MEM_WB !== 16'h0000) begin
      errors++; $display("FAIL prio_memdata: got %h, required 0000", memData_MEM_WB);
    end
  endtask

  task automatic test_stall_bubble();
    drive_alu(4'd9, 16'h0999, 1'b0, 16'h0200);
    @(negedge clk);
    ex_valid = 1; ex_memRe = 1; ex_memWe = 0; ex_aluResult = 16'h0080; ex_wrtData = '0;
    ex_pcNext = 16'h0082; ex_regAddr = 4'd10; ex_regWe = 1; ex_jal = 0; ex_memToReg = 1;
    push_exp(4'd10, 1'b1, 1'b0, 1'b1, 16'h0080, 16'h0082, 16'h7777, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL bubble_idle_stall: got stall=%b, required 1", stall); end
    @(negedge clk);
    checks++;
    if (valid_MEM_WB !== 1'b0 || regWe_MEM_WB !== 1'b0 || regAddr_MEM_WB !== 4'd9 || aluResult_MEM_WB !== 16'h0999) begin
      errors++; $display("FAIL bubble_first_edge: got v=%b we=%b ra=%0d alu=%h, required 0 0 9 0999",
                         valid_MEM_WB, regWe_MEM_WB, regAddr_MEM_WB, aluResult_MEM_WB);
    end
    mem_ack = 1'b1;
    mem_rdata = 16'h7777;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (valid_MEM_WB !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL bubble_complete: got v=%b stall=%b req=%b, required 0 0 0", valid_MEM_WB, stall, mem_req);
    end
    @(negedge clk);
    checks++;
    if (valid_MEM_WB !== 1'b1 || regAddr_MEM_WB !== 4'd10 || memData_MEM_WB !== 16'h7777) begin
      errors++; $display("FAIL bubble_load_wb: got v=%b ra=%0d md=%h, required 1 10 7777", valid_MEM_WB, regAddr_MEM_WB, memData_MEM_WB);
    end
    set_idle();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int st, rq, er, bad;
    bit hung;
    push_exp(4'd5, 1'b0, 1'b0, 1'b1, 16'h0050, 16'h0052, 16'h0000, 1'b1);
    do_access(16'h0050, 16'h0000, 1'b1, 1'b0, 4'd5, 1'b1, 0, 16'hFFFF, st, rq, er, bad, hung);
    checks++;
    if (hung || rq != 15 || st != 16) begin
      errors++; $display("FAIL timeout_cycles: got req_cycles=%0d stalls=%0d hung=%0d, required 15 16 0", rq, st, hung);
    end
    checks++;
    if (er != 1 || regWe_MEM_WB !== 1'b0 || memData_MEM_WB !== 16'h0000 || valid_MEM_WB !== 1'b1) begin
      errors++; $display("FAIL timeout_err: got err_cycles=%0d we=%b md=%h v=%b, required 1 0 0000 1", er, regWe_MEM_WB, memData_MEM_WB, valid_MEM_WB);
    end
    @(negedge clk);
    checks++;
    if (mem_err !== 1'b0) begin errors++; $display("FAIL timeout_pulse: got mem_err=%b, required 0", mem_err); end
    push_exp(4'd6, 1'b1, 1'b0, 1'b1, 16'h0060, 16'h0062, 16'h5A5A, 1'b1);
    do_access(16'h0060, 16'h0000, 1'b1, 1'b0, 4'd6, 1'b1, 15, 16'h5A5A, st, rq, er, bad, hung);
    checks++;
    if (hung || rq != 15 || er != 0 || regWe_MEM_WB !== 1'b1 || memData_MEM_WB !== 16'h5A5A) begin
      errors++; $display("FAIL timeout_late_ack: got req_cycles=%0d err=%0d we=%b md=%h, required 15 0 1 5A5A", rq, er, regWe_MEM_WB, memData_MEM_WB);
    end
  endtask
`endif

  task automatic test_reset_mid_access();
    drive_alu(4'd7, 16'h0BAD, 1'b1, 16'h0300);
    @(negedge clk);
    ex_valid = 1; ex_memRe = 1; ex_memWe = 0; ex_aluResult = 16'h0040; ex_wrtData = '0;
    ex_pcNext = 16'h0042; ex_regAddr = 4'd3; ex_regWe = 1; ex_jal = 0; ex_memToReg = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got mem_req=%b, required 1", mem_req); end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req_async: got mem_req=%b, required 0", mem_req); end
    checks++;
    if ({valid_MEM_WB, regWe_MEM_WB, jal_MEM_WB, memToReg_MEM_WB} !== 4'b0000 || regAddr_MEM_WB !== '0 ||
        {aluResult_MEM_WB, pcNext_MEM_WB, memData_MEM_WB} !== '0) begin
      errors++; $display("FAIL rst_wb_clear: got v=%b ra=%0d alu=%h pc=%h md=%h, required all 0",
                         valid_MEM_WB, regAddr_MEM_WB, aluResult_MEM_WB, pcNext_MEM_WB, memData_MEM_WB);
    end
    set_idle();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0 || valid_MEM_WB !== 1'b0) begin
      errors++; $display("FAIL rst_idle_after: got stall=%b req=%b v=%b, required 0 0 0", stall, mem_req, valid_MEM_WB);
    end
    drive_alu(4'd8, 16'h0888, 1'b0, 16'h0400);
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL rst_alu_stall: got stall=%b, required 0", stall); end
    @(negedge clk);
    checks++;
    if (regAddr_MEM_WB !== 4'd8 || aluResult_MEM_WB !== 16'h0888) begin
      errors++; $display("FAIL rst_alu_wb: got ra=%0d alu=%h, required 8 0888", regAddr_MEM_WB, aluResult_MEM_WB);
    end
    set_idle();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0;
    mem_ack = 0;
    mem_rdata = '0;
    set_idle();
    test_reset();
    test_back_to_back();
    test_load();
    test_store();
    test_store_priority();
    test_stall_bubble();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_access();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d outstanding entries, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
